// File: rtl/ps2_famicom_pad.sv
// PS/2 keyboard and hps_io joystick merged into an 8-button Famicom serial pad.
// The shell's latch/pulse are synchronised into clk_sys before driving the shift register.
module ps2_famicom_pad #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  SC_A        = 8'h22,
  parameter logic [7:0]  SC_B        = 8'h1A,
  parameter logic [7:0]  SC_SELECT   = 8'h66,
  parameter logic [7:0]  SC_START    = 8'h5A,
  parameter logic [7:0]  SC_UP       = 8'h75,
  parameter logic [7:0]  SC_DOWN     = 8'h72,
  parameter logic [7:0]  SC_LEFT     = 8'h6B,
  parameter logic [7:0]  SC_RIGHT    = 8'h74
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  joy,
  input  logic        famicom_latch,
  input  logic        famicom_pulse,
  output logic        famicom_data,
  output logic [7:0]  pad_state
);

  localparam int unsigned PadW = 8;

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] pulse_sync_q;
  logic                   pulse_prev_q;
  logic                   armed_q;
  logic                   toggle_prev_q;
  logic [PadW-1:0]        key_state_q;
  logic [PadW-1:0]        key_state_d;
  logic [PadW-1:0]        pad_state_q;
  logic [PadW-1:0]        shift_q;
  logic [PadW-1:0]        shift_d;
  logic                   data_q;

  logic                   latch_s_c;
  logic                   pulse_rise_c;
  logic                   key_evt_c;
  logic [PadW-1:0]        key_hit_c;

  assign latch_s_c    = latch_sync_q[SYNC_STAGES-1];
  assign pulse_rise_c = pulse_sync_q[SYNC_STAGES-1] & ~pulse_prev_q;
  assign key_evt_c    = armed_q & (ps2_key[10] != toggle_prev_q);

  // A button matches only when both scancode and extended flag agree.
  always_comb begin
    key_hit_c    = '0;
    key_hit_c[7] = (ps2_key[7:0] == SC_A)      & ~ps2_key[8];
    key_hit_c[6] = (ps2_key[7:0] == SC_B)      & ~ps2_key[8];
    key_hit_c[5] = (ps2_key[7:0] == SC_SELECT) & ~ps2_key[8];
    key_hit_c[4] = (ps2_key[7:0] == SC_START)  & ~ps2_key[8];
    key_hit_c[3] = (ps2_key[7:0] == SC_UP)     &  ps2_key[8];
    key_hit_c[2] = (ps2_key[7:0] == SC_DOWN)   &  ps2_key[8];
    key_hit_c[1] = (ps2_key[7:0] == SC_LEFT)   &  ps2_key[8];
    key_hit_c[0] = (ps2_key[7:0] == SC_RIGHT)  &  ps2_key[8];
  end

  always_comb begin
    key_state_d = key_state_q;
    if (key_evt_c) begin
      key_state_d = (key_state_q & ~key_hit_c) | (key_hit_c & {PadW{ps2_key[9]}});
    end
  end

  // Load wins over shift; shifting refills with released (1) bits.
  always_comb begin
    shift_d = shift_q;
    if (latch_s_c) begin
      shift_d = ~pad_state_q;
    end else if (pulse_rise_c) begin
      shift_d = {shift_q[PadW-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync_q  <= '0;
      pulse_sync_q  <= '0;
      pulse_prev_q  <= 1'b0;
      armed_q       <= 1'b0;
      toggle_prev_q <= 1'b0;
      key_state_q   <= '0;
      pad_state_q   <= '0;
      shift_q       <= '1;
      data_q        <= 1'b1;
    end else begin
      latch_sync_q  <= {latch_sync_q[SYNC_STAGES-2:0], famicom_latch};
      pulse_sync_q  <= {pulse_sync_q[SYNC_STAGES-2:0], famicom_pulse};
      pulse_prev_q  <= pulse_sync_q[SYNC_STAGES-1];
      armed_q       <= 1'b1;
      toggle_prev_q <= ps2_key[10];
      key_state_q   <= key_state_d;
      pad_state_q   <= key_state_q | joy;
      shift_q       <= shift_d;
      data_q        <= shift_q[PadW-1];
    end
  end

  assign famicom_data = data_q;
  assign pad_state    = pad_state_q;

endmodule

// File: tb/tb_ps2_famicom_pad.sv
// Randomised bench for ps2_famicom_pad against a button-list model of the pad.
module tb_ps2_famicom_pad;

  localparam int unsigned SYNC = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [7:0]  joy;
  logic        famicom_latch;
  logic        famicom_pulse;
  logic        famicom_data;
  logic [7:0]  pad_state;

  always #5 clk_sys = ~clk_sys;

  ps2_famicom_pad #(.SYNC_STAGES(SYNC)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .joy           (joy),
    .famicom_latch (famicom_latch),
    .famicom_pulse (famicom_pulse),
    .famicom_data  (famicom_data),
    .pad_state     (pad_state)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_key;
  logic [7:0] m_snap;
  int         m_reads;
  logic       tog;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pad bit index of a key, or -1 when the key is not a pad button.
  function automatic int btn_index(input logic ext, input logic [7:0] code);
    if (!ext) begin
      case (code)
        8'h22: return 7;
        8'h1A: return 6;
        8'h66: return 5;
        8'h5A: return 4;
        default: return -1;
      endcase
    end
    case (code)
      8'h75: return 3;
      8'h72: return 2;
      8'h6B: return 1;
      8'h74: return 0;
      default: return -1;
    endcase
  endfunction

  // Serial bit expected after m_reads shifts of the captured snapshot.
  function automatic logic exp_data();
    if (m_reads < 8) return ~m_snap[7-m_reads];
    return 1'b1;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_key(input logic pr, input logic ext, input logic [7:0] code);
    int idx;
    @(negedge clk_sys);
    tog = ~tog;
    ps2_key = {tog, pr, ext, code};
    idx = btn_index(ext, code);
    if (idx >= 0) m_key[idx] = pr;
    wait_clk(4);
    check("pad_after_key", pad_state, m_key | joy);
  endtask

  task automatic set_joy(input logic [7:0] v);
    @(negedge clk_sys);
    joy = v;
    wait_clk(3);
    check("pad_after_joy", pad_state, m_key | joy);
  endtask

  task automatic do_latch(input logic glitch);
    @(negedge clk_sys);
    famicom_latch = 1'b1;
    m_snap  = m_key | joy;
    m_reads = 0;
    repeat (SYNC + 2) @(posedge clk_sys);
    #1 check("load_latency", famicom_data, exp_data());
    if (glitch) begin
      @(negedge clk_sys);
      famicom_pulse = 1'b1;
      wait_clk(2);
      famicom_pulse = 1'b0;
      wait_clk(SYNC + 2);
    end
    @(negedge clk_sys);
    famicom_latch = 1'b0;
    wait_clk(SYNC + 3);
    check("after_latch", famicom_data, exp_data());
  endtask

  task automatic do_pulse();
    @(negedge clk_sys);
    famicom_pulse = 1'b1;
    m_reads++;
    repeat (SYNC + 2) @(posedge clk_sys);
    #1 check("shift_latency", famicom_data, exp_data());
    @(negedge clk_sys);
    famicom_pulse = 1'b0;
    wait_clk(2);
  endtask

  task automatic read_pad(input int pulses);
    do_latch(1'b0);
    for (int i = 0; i < pulses; i++) do_pulse();
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    m_key   = '0;
    m_reads = 8;
    #1 check("reset_data", famicom_data, 8'h01);
    check("reset_pad", pad_state, 8'h00);
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(3);
  endtask

  initial begin
    logic [7:0] codes [10];
    codes = '{8'h22, 8'h1A, 8'h66, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h29};
    reset_n = 1'b0;
    ps2_key = '0;
    joy = '0;
    famicom_latch = 1'b0;
    famicom_pulse = 1'b0;
    tog = 1'b0;
    m_key = '0;
    m_snap = '0;
    m_reads = 8;
    wait_clk(3);
    check("init_data", famicom_data, 8'h01);
    check("init_pad", pad_state, 8'h00);
    reset_n = 1'b1;
    wait_clk(3);

    // Idle pad: all released, including a ninth read.
    read_pad(9);

    // A alone.
    send_key(1'b1, 1'b0, 8'h22);
    check("pad_A", pad_state, 8'h80);
    read_pad(8);
    send_key(1'b0, 1'b0, 8'h22);

    // Extended Up counts; non-extended 75 is ignored.
    send_key(1'b1, 1'b1, 8'h75);
    send_key(1'b1, 1'b0, 8'h75);
    check("pad_up", pad_state, 8'h08);
    read_pad(8);
    send_key(1'b0, 1'b1, 8'h75);
    check("pad_up_rel", pad_state, 8'h00);

    // Keyboard and joystick OR together.
    send_key(1'b1, 1'b1, 8'h6B);
    set_joy(8'h02);
    set_joy(8'h00);
    check("left_held", pad_state, 8'h02);
    send_key(1'b0, 1'b1, 8'h6B);
    check("left_rel", pad_state, 8'h00);

    // Relatch mid-sequence with B held; pulse during latch is ignored.
    send_key(1'b1, 1'b0, 8'h1A);
    read_pad(3);
    do_latch(1'b1);
    for (int i = 0; i < 8; i++) do_pulse();
    send_key(1'b0, 1'b0, 8'h1A);

    // Reset mid-sequence aborts; next read restarts from A.
    send_key(1'b1, 1'b0, 8'h5A);
    read_pad(3);
    do_reset();
    read_pad(8);

    // Toggle held high through reset release must not create an event.
    @(negedge clk_sys);
    reset_n = 1'b0;
    tog = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h5A};
    m_key = '0;
    m_reads = 8;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(4);
    check("arm_no_event", pad_state, 8'h00);
    send_key(1'b1, 1'b0, 8'h5A);
    check("pad_start", pad_state, 8'h10);

    // Random mix of key events, joystick changes and reads.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: send_key(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       codes[$urandom_range(0, 9)]);
        2: set_joy(8'($urandom));
        default: begin
          do_latch(1'($urandom_range(0, 1)));
          for (int p = $urandom_range(0, 10); p > 0; p--) begin
            if ($urandom_range(0, 3) == 0)
              send_key(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       codes[$urandom_range(0, 9)]);
            do_pulse();
          end
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
